// File: rtl/dpll_control_core_if.sv
// BCP engine handshake bundle for dpll_control_core: the controller announces each
// assignment to propagate and the engine returns implications and a done/conflict result.
interface dpll_control_core_if #(
    parameter int NUM_VARIABLE   = 128,
    parameter int VARIABLE_INDEX = $clog2(NUM_VARIABLE)
);
    logic                      bcp_start;
    logic [VARIABLE_INDEX-1:0] bcp_var;
    logic                      bcp_val;
    logic                      bcp_imply_valid;
    logic [VARIABLE_INDEX-1:0] bcp_imply_var;
    logic                      bcp_imply_val;
    logic                      bcp_done;
    logic                      bcp_conflict;

    modport master (
        output bcp_start, bcp_var, bcp_val,
        input  bcp_imply_valid, bcp_imply_var, bcp_imply_val, bcp_done, bcp_conflict
    );

    modport slave (
        input  bcp_start, bcp_var, bcp_val,
        output bcp_imply_valid, bcp_imply_var, bcp_imply_val, bcp_done, bcp_conflict
    );
endinterface

// File: rtl/dpll_control_core.sv
// DPLL search controller: decisions, implication trail and chronological backtracking.
// Optional DPLL_CONTROL_STATS_EN adds saturating decision / backtrack-pop counters.
module dpll_control_core #(
    parameter int   NUM_VARIABLE     = 128,
    parameter int   VARIABLE_INDEX   = $clog2(NUM_VARIABLE),
    parameter logic DEFAULT_POLARITY = 1'b0,
    parameter int   MAX_CONFLICTS    = 0,
    parameter int   CONFLICT_WIDTH   = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    dpll_control_core_if.master     bcp,
    output logic [NUM_VARIABLE-1:0] assigned,
    output logic [NUM_VARIABLE-1:0] assignment,
    output logic                    busy,
    output logic                    sat,
    output logic                    unsat,
    output logic                    timeout
`ifdef DPLL_CONTROL_STATS_EN
    ,
    output logic [31:0]             decision_count,
    output logic [31:0]             backtrack_pop_count
`endif
);

    localparam int PW = $clog2(NUM_VARIABLE + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECIDE,
        S_BCP_WAIT,
        S_BACKTRACK,
        S_SAT,
        S_UNSAT,
        S_TIMEOUT
    } state_t;

    state_t state, state_nx;

    // Trail storage; only entries below tp are meaningful, so no reset is needed.
    logic [VARIABLE_INDEX-1:0] tr_var  [NUM_VARIABLE];
    logic                      tr_val  [NUM_VARIABLE];
    logic                      tr_dec  [NUM_VARIABLE];
    logic                      tr_flip [NUM_VARIABLE];

    logic [PW-1:0]             tp;
    logic [VARIABLE_INDEX-1:0] push_idx;
    logic [VARIABLE_INDEX-1:0] top_idx;
    logic [CONFLICT_WIDTH-1:0] conflicts;
    logic [CONFLICT_WIDTH-1:0] conflicts_inc;

    logic [VARIABLE_INDEX-1:0] free_var;
    logic                      all_assigned;
    logic                      imp_new;
    logic                      imp_clash;
    logic                      limit_hit;

    logic                      push_en;
    logic [VARIABLE_INDEX-1:0] push_var;
    logic                      push_val;
    logic                      push_dec;
    logic                      flip_en;
    logic                      pop_en;
    logic                      clear_all;
    logic                      fire;
    logic [VARIABLE_INDEX-1:0] fire_var;
    logic                      fire_val;
    logic                      cnt_inc;

    assign push_idx      = VARIABLE_INDEX'(tp);
    assign top_idx       = VARIABLE_INDEX'(tp - 1'b1);
    assign conflicts_inc = conflicts + 1'b1;
    assign all_assigned  = &assigned;
    assign limit_hit     = (MAX_CONFLICTS != 0) &&
                           (conflicts_inc == CONFLICT_WIDTH'(MAX_CONFLICTS));

    assign imp_new   = bcp.bcp_imply_valid && !assigned[bcp.bcp_imply_var];
    assign imp_clash = bcp.bcp_imply_valid && assigned[bcp.bcp_imply_var] &&
                       (assignment[bcp.bcp_imply_var] != bcp.bcp_imply_val);

    // Lowest-index unassigned variable (scan from the top so index 0 wins).
    always_comb begin
        free_var = '0;
        for (int i = NUM_VARIABLE - 1; i >= 0; i--) begin
            if (!assigned[i]) free_var = VARIABLE_INDEX'(i);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        push_en   = 1'b0;
        push_var  = '0;
        push_val  = 1'b0;
        push_dec  = 1'b0;
        flip_en   = 1'b0;
        pop_en    = 1'b0;
        clear_all = 1'b0;
        fire      = 1'b0;
        fire_var  = '0;
        fire_val  = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            S_IDLE, S_SAT, S_UNSAT, S_TIMEOUT: begin
                if (start) begin
                    clear_all = 1'b1;
                    state_nx  = S_DECIDE;
                end
            end
            S_DECIDE: begin
                if (all_assigned) begin
                    state_nx = S_SAT;
                end else begin
                    push_en  = 1'b1;
                    push_var = free_var;
                    push_val = DEFAULT_POLARITY;
                    push_dec = 1'b1;
                    fire     = 1'b1;
                    fire_var = free_var;
                    fire_val = DEFAULT_POLARITY;
                    state_nx = S_BCP_WAIT;
                end
            end
            S_BCP_WAIT: begin
                // A fresh implication is recorded in the same cycle done is acted on.
                if (imp_new) begin
                    push_en  = 1'b1;
                    push_var = bcp.bcp_imply_var;
                    push_val = bcp.bcp_imply_val;
                end
                if (imp_clash || (bcp.bcp_done && bcp.bcp_conflict)) begin
                    cnt_inc  = 1'b1;
                    state_nx = limit_hit ? S_TIMEOUT : S_BACKTRACK;
                end else if (bcp.bcp_done) begin
                    state_nx = S_DECIDE;
                end
            end
            S_BACKTRACK: begin
                if (tp == '0) begin
                    state_nx = S_UNSAT;
                end else if (tr_dec[top_idx] && !tr_flip[top_idx]) begin
                    flip_en  = 1'b1;
                    fire     = 1'b1;
                    fire_var = tr_var[top_idx];
                    fire_val = ~tr_val[top_idx];
                    state_nx = S_BCP_WAIT;
                end else begin
                    pop_en = 1'b1;
                    if (tp == PW'(1)) state_nx = S_UNSAT;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            assigned      <= '0;
            assignment    <= '0;
            tp            <= '0;
            conflicts     <= '0;
            bcp.bcp_start <= 1'b0;
            bcp.bcp_var   <= '0;
            bcp.bcp_val   <= 1'b0;
        end else begin
            bcp.bcp_start <= fire;
            if (fire) begin
                bcp.bcp_var <= fire_var;
                bcp.bcp_val <= fire_val;
            end
            if (clear_all) begin
                assigned   <= '0;
                assignment <= '0;
                tp         <= '0;
                conflicts  <= '0;
            end
            if (push_en) begin
                assigned[push_var]   <= 1'b1;
                assignment[push_var] <= push_val;
                tp                   <= tp + 1'b1;
            end
            if (flip_en) assignment[fire_var] <= fire_val;
            if (pop_en) begin
                assigned[tr_var[top_idx]] <= 1'b0;
                tp                        <= tp - 1'b1;
            end
            if (cnt_inc) conflicts <= conflicts_inc;
        end
    end

    always_ff @(posedge clock) begin
        if (push_en) begin
            tr_var[push_idx]  <= push_var;
            tr_val[push_idx]  <= push_val;
            tr_dec[push_idx]  <= push_dec;
            tr_flip[push_idx] <= 1'b0;
        end
        if (flip_en) begin
            tr_val[top_idx]  <= fire_val;
            tr_flip[top_idx] <= 1'b1;
        end
    end

    assign busy    = (state == S_DECIDE) || (state == S_BCP_WAIT) || (state == S_BACKTRACK);
    assign sat     = (state == S_SAT);
    assign unsat   = (state == S_UNSAT);
    assign timeout = (state == S_TIMEOUT);

`ifdef DPLL_CONTROL_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] x);
        return (&x) ? x : x + 32'd1;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            decision_count      <= '0;
            backtrack_pop_count <= '0;
        end else if (clear_all) begin
            decision_count      <= '0;
            backtrack_pop_count <= '0;
        end else begin
            if (push_en && push_dec) decision_count <= sat_inc(decision_count);
            if (pop_en) backtrack_pop_count <= sat_inc(backtrack_pop_count);
        end
    end
`endif

endmodule

// File: tb/tb_dpll_control_core.sv
// Bench for dpll_control_core: BCP responder models plus a queue of expected bcp_start pulses.
module tb_dpll_control_core;

    localparam int NV = 4;

    logic clk = 1'b0;
    logic rst;
    logic start_a, start_b;
    logic [NV-1:0] assigned_a, assignment_a, assigned_b, assignment_b;
    logic busy_a, sat_a, unsat_a, to_a;
    logic busy_b, sat_b, unsat_b, to_b;
`ifdef DPLL_CONTROL_STATS_EN
    logic [31:0] dc_a, bp_a, dc_b, bp_b;
`endif

    dpll_control_core_if #(.NUM_VARIABLE(NV)) bif_a ();
    dpll_control_core_if #(.NUM_VARIABLE(NV)) bif_b ();

    dpll_control_core #(.NUM_VARIABLE(NV), .MAX_CONFLICTS(0)) dut_a (
        .clock(clk), .reset(rst), .start(start_a), .bcp(bif_a.master),
        .assigned(assigned_a), .assignment(assignment_a),
        .busy(busy_a), .sat(sat_a), .unsat(unsat_a), .timeout(to_a)
`ifdef DPLL_CONTROL_STATS_EN
        , .decision_count(dc_a), .backtrack_pop_count(bp_a)
`endif
    );

    dpll_control_core #(.NUM_VARIABLE(NV), .MAX_CONFLICTS(1)) dut_b (
        .clock(clk), .reset(rst), .start(start_b), .bcp(bif_b.master),
        .assigned(assigned_b), .assignment(assignment_b),
        .busy(busy_b), .sat(sat_b), .unsat(unsat_b), .timeout(to_b)
`ifdef DPLL_CONTROL_STATS_EN
        , .decision_count(dc_b), .backtrack_pop_count(bp_b)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pv(input int v, input logic b);
        return 8'(v * 2 + int'(b));
    endfunction

    // Expected bcp_start pulses {var,val}, pushed by the stimulus and popped by the responders.
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];

    localparam int M_OK = 0, M_CONF = 1, M_IMPL = 2, M_STALL = 3;
    int mode_a   = M_OK;
    int kick_req = 0;
    int kick_ack = 0;
    int pulses_a = 0;
    int impl_step = 0;
    bit impl_used = 1'b0;

    initial begin
        bif_a.bcp_done = 0; bif_a.bcp_conflict = 0;
        bif_a.bcp_imply_valid = 0; bif_a.bcp_imply_var = '0; bif_a.bcp_imply_val = 0;
        forever begin
            logic [7:0] e;
            @(negedge clk);
            bif_a.bcp_done = 0; bif_a.bcp_conflict = 0; bif_a.bcp_imply_valid = 0;
            if (kick_req != kick_ack) begin
                kick_ack++;
                bif_a.bcp_done = 1;
            end else if (impl_step == 1) begin
                bif_a.bcp_imply_valid = 1; bif_a.bcp_imply_var = 2'd1; bif_a.bcp_imply_val = 0;
                impl_step = 2;
            end else if (impl_step == 2) begin
                bif_a.bcp_done = 1;
                impl_step = 0;
            end
            if (bif_a.bcp_start) begin
                pulses_a++;
                e = (exp_a.size() > 0) ? exp_a.pop_front() : 8'hFF;
                check_val("a_pulse", 8'({bif_a.bcp_var, bif_a.bcp_val}), e);
                case (mode_a)
                    M_OK:   bif_a.bcp_done = 1;
                    M_CONF: begin bif_a.bcp_done = 1; bif_a.bcp_conflict = 1; end
                    M_IMPL: begin
                        if (!impl_used) begin
                            impl_used = 1'b1;
                            bif_a.bcp_imply_valid = 1; bif_a.bcp_imply_var = 2'd2;
                            bif_a.bcp_imply_val = 1;
                            impl_step = 1;
                        end else begin
                            bif_a.bcp_done = 1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    initial begin
        bif_b.bcp_done = 0; bif_b.bcp_conflict = 0;
        bif_b.bcp_imply_valid = 0; bif_b.bcp_imply_var = '0; bif_b.bcp_imply_val = 0;
        forever begin
            logic [7:0] e;
            @(negedge clk);
            bif_b.bcp_done = 0; bif_b.bcp_conflict = 0;
            if (bif_b.bcp_start) begin
                e = (exp_b.size() > 0) ? exp_b.pop_front() : 8'hFF;
                check_val("b_pulse", 8'({bif_b.bcp_var, bif_b.bcp_val}), e);
                bif_b.bcp_done = 1; bif_b.bcp_conflict = 1;
            end
        end
    end

    task automatic pulse_start_a();
        @(negedge clk); start_a = 1;
        @(negedge clk); start_a = 0;
    endtask

    task automatic wait_term_a(input string tag);
        int n = 0;
        while (!(sat_a || unsat_a || to_a) && n < 200) begin @(negedge clk); n++; end
        check_val(tag, (sat_a || unsat_a || to_a), 1);
    endtask

    task automatic wait_pulses_a(input string tag, input int target);
        int n = 0;
        while (pulses_a < target && n < 50) begin @(negedge clk); n++; end
        check_val(tag, pulses_a, target);
    endtask

    task automatic push_all_zero();
        for (int v = 0; v < NV; v++) exp_a.push_back(pv(v, 1'b0));
    endtask

    task automatic check_sat_all_zero(input string tag);
        check_val({tag, "_sat"},   sat_a, 1);
        check_val({tag, "_unsat"}, unsat_a, 0);
        check_val({tag, "_asgd"},  assigned_a, 4'b1111);
        check_val({tag, "_asgn"},  assignment_a, 4'b0000);
        check_val({tag, "_busy"},  busy_a, 0);
        check_val({tag, "_qlen"},  exp_a.size(), 0);
    endtask

    initial begin
        int base;
        int n;
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int n;
        rst = 1; start_a = 0; start_b = 0;
        repeat (3) @(negedge clk);
        check_val("rst_asgd",  assigned_a, 0);
        check_val("rst_asgn",  assignment_a, 0);
        check_val("rst_flags", {busy_a, sat_a, unsat_a, to_a, bif_a.bcp_start}, 0);
        check_val("rst_bvar",  {bif_a.bcp_var, bif_a.bcp_val}, 0);
        rst = 0;
        @(negedge clk);
        check_val("idle_busy", busy_a, 0);

        // All-clear propagation: one decision per variable, all at default polarity.
        mode_a = M_OK;
        push_all_zero();
        pulse_start_a();
        wait_term_a("t1_term");
        check_sat_all_zero("t1");
        repeat (3) @(negedge clk);
        check_val("t1_sticky", {sat_a, busy_a}, 2'b10);
`ifdef DPLL_CONTROL_STATS_EN
        check_val("t1_dcnt", dc_a, 4);
        check_val("t1_bpop", bp_a, 0);
`endif

        // Every propagation conflicts: var0 tried both ways, then the trail empties.
        mode_a = M_CONF;
        exp_a.push_back(pv(0, 1'b0));
        exp_a.push_back(pv(0, 1'b1));
        pulse_start_a();
        wait_term_a("t2_term");
        check_val("t2_unsat", unsat_a, 1);
        check_val("t2_sat",   sat_a, 0);
        check_val("t2_asgd",  assigned_a, 0);
        check_val("t2_busy",  busy_a, 0);
        check_val("t2_qlen",  exp_a.size(), 0);
`ifdef DPLL_CONTROL_STATS_EN
        check_val("t2_dcnt", dc_a, 1);
        check_val("t2_bpop", bp_a, 1);
`endif

        // Implications var2=1, var1=0 after the first decision; next decision is var3.
        mode_a = M_IMPL;
        exp_a.push_back(pv(0, 1'b0));
        exp_a.push_back(pv(3, 1'b0));
        pulse_start_a();
        wait_term_a("t3_term");
        check_val("t3_sat",  sat_a, 1);
        check_val("t3_asgd", assigned_a, 4'b1111);
        check_val("t3_asgn", assignment_a, 4'b0100);
        check_val("t3_qlen", exp_a.size(), 0);

        // Asynchronous reset while waiting on BCP with two trail entries.
        mode_a = M_STALL;
        base = pulses_a;
        exp_a.push_back(pv(0, 1'b0));
        exp_a.push_back(pv(1, 1'b0));
        pulse_start_a();
        wait_pulses_a("t4_p1", base + 1);
        kick_req++;
        wait_pulses_a("t4_p2", base + 2);
        check_val("t4_pre_asgd", assigned_a, 4'b0011);
        check_val("t4_pre_busy", busy_a, 1);
        #2 rst = 1;
        #1;
        check_val("t4_asgd",  assigned_a, 0);
        check_val("t4_asgn",  assignment_a, 0);
        check_val("t4_flags", {busy_a, sat_a, unsat_a, to_a, bif_a.bcp_start}, 0);
        check_val("t4_bvar",  {bif_a.bcp_var, bif_a.bcp_val}, 0);
        @(negedge clk);
        rst = 0;
        mode_a = M_OK;
        push_all_zero();
        pulse_start_a();
        wait_term_a("t4r_term");
        check_sat_all_zero("t4r");

        // start while busy is ignored.
        mode_a = M_STALL;
        base = pulses_a;
        push_all_zero();
        pulse_start_a();
        wait_pulses_a("t5_p1", base + 1);
        pulse_start_a();
        repeat (3) @(negedge clk);
        check_val("t5_asgd",   assigned_a, 4'b0001);
        check_val("t5_busy",   busy_a, 1);
        check_val("t5_pulses", pulses_a, base + 1);
        mode_a = M_OK;
        kick_req++;
        wait_term_a("t5_term");
        check_sat_all_zero("t5");

        // Conflict limit of one: timeout after the first conflict, nothing popped.
        exp_b.push_back(pv(0, 1'b0));
        @(negedge clk); start_b = 1;
        @(negedge clk); start_b = 0;
        n = 0;
        while (!(sat_b || unsat_b || to_b) && n < 200) begin @(negedge clk); n++; end
        check_val("t6_term", (sat_b || unsat_b || to_b), 1);
        repeat (3) @(negedge clk);
        check_val("t6_flags", {to_b, sat_b, unsat_b, busy_b}, 4'b1000);
        check_val("t6_asgd",  assigned_b, 4'b0001);
        check_val("t6_asgn",  assignment_b, 4'b0000);
        check_val("t6_qlen",  exp_b.size(), 0);
`ifdef DPLL_CONTROL_STATS_EN
        check_val("t6_bpop", bp_b, 0);
        check_val("t6_dcnt", dc_b, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dpll_control_core.md
Name: dpll_control_core

Overview:
- Parametrised DPLL search controller; next generation of the solver top-level control FSM.
- Owns the assignment state, the decision/implication trail and chronological backtracking.
- Drives an external BCP engine through a start/done handshake.
- Reports sat, unsat or timeout to the top level.

Parameters:
- NUM_VARIABLE, 128: number of variables; trail depth.
- VARIABLE_INDEX, $clog2(NUM_VARIABLE): width of a variable index.
- DEFAULT_POLARITY, 0: value assigned on a fresh decision.
- MAX_CONFLICTS, 0: conflict limit before timeout; 0 means unlimited.
- CONFLICT_WIDTH, 16: conflict counter width.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a solve; honoured only in IDLE or a terminal state.
- bcp_start  out  1  one-cycle pulse; propagate the assignment on bcp_var/bcp_val.
- bcp_var  out  VARIABLE_INDEX  variable just assigned.
- bcp_val  out  1  value just assigned.
- bcp_imply_valid  in  1  implication present this cycle.
- bcp_imply_var  in  VARIABLE_INDEX  implied variable.
- bcp_imply_val  in  1  implied value.
- bcp_done  in  1  propagation finished.
- bcp_conflict  in  1  qualifies bcp_done; conflict found.
- assigned  out  NUM_VARIABLE  per-variable assigned flag.
- assignment  out  NUM_VARIABLE  per-variable value; only meaningful where assigned=1.
- busy  out  1  high in DECIDE, BCP_WAIT and BACKTRACK.
- sat  out  1  sticky; formula satisfied.
- unsat  out  1  sticky; formula unsatisfiable.
- timeout  out  1  sticky; conflict limit hit.

Behaviour:
- Reset: all outputs 0, trail pointer 0, conflict counter 0, state IDLE.
- Trail: NUM_VARIABLE entries of {var, val, is_decision, flipped}; one push or pop per cycle.
- start in IDLE/SAT/UNSAT/TIMEOUT:
  - Clears assigned, the trail, the counter and sat/unsat/timeout.
  - Next state is DECIDE.
- start while busy is ignored.
- DECIDE (1 cycle):
  - If all variables are assigned: go to SAT; sat=1 from the next cycle.
  - Otherwise take the lowest-index unassigned variable and assign it DEFAULT_POLARITY.
  - Push {v, DEFAULT_POLARITY, decision=1, flipped=0}.
  - Pulse bcp_start with bcp_var=v, then go to BCP_WAIT.
- BCP_WAIT:
  - Each cycle with bcp_imply_valid and an unassigned variable: assign it and push {var, val, 0, 0}.
  - Implication on an already-assigned variable with the same value: ignored.
  - Implication on an already-assigned variable with the opposite value: treated as bcp_done with bcp_conflict.
  - bcp_done with bcp_conflict=0: go to DECIDE.
  - bcp_done with bcp_conflict=1: increment the conflict counter; go to TIMEOUT if the counter equals MAX_CONFLICTS and MAX_CONFLICTS≠0, else go to BACKTRACK.
  - Implication and done in the same cycle: the implication is applied first, then done is acted on.
- BACKTRACK (one entry examined per cycle):
  - Top entry is a decision with flipped=0: invert its value in place, set flipped=1, update assignment, pulse bcp_start with that variable, go to BCP_WAIT.
  - Any other top entry: pop it and clear its assigned bit.
  - If the pop empties the trail: go to UNSAT; unsat=1 from the next cycle.
- Terminal states hold their flag and the final assignment until start or reset.
- bcp_var and bcp_val hold their last value between pulses.
- Reset asserted in any state, including mid-BCP or mid-backtrack: immediate return to reset values.

Optional Feature:
- Macro: DPLL_CONTROL_STATS_EN.
- Defined: adds output ports decision_count (32) and backtrack_pop_count (32).
  - Both are cleared by reset and by an accepted start.
  - decision_count increments on each DECIDE push.
  - backtrack_pop_count increments on each BACKTRACK pop.
  - Both saturate at all-ones.
- Undefined: neither port nor counter exists; core behaviour is identical.

Test Plan:
- NUM_VARIABLE=4; bench answers bcp_done=1, bcp_conflict=0 one cycle after each bcp_start, with no implications -> exactly 4 bcp_start pulses on vars 0,1,2,3 with val 0; sat=1, assigned=4'b1111, assignment=4'b0000, busy=0.
- NUM_VARIABLE=4; bench always answers bcp_conflict=1 -> pulses (var0,val0) then (var0,val1); unsat=1; assigned=0; conflict counter 2.
- NUM_VARIABLE=4; after the first pulse (var0,val0) the bench implies var2=1 and var1=0 on consecutive cycles, then done without conflict -> next decision is var3; sat with assignment=4'b0100 (bit2=1, others 0).
- MAX_CONFLICTS=1; bench always conflicts -> timeout=1 after the first conflict; sat=0, unsat=0; no BACKTRACK pop occurs.
- Reset asserted while in BCP_WAIT with 2 trail entries -> outputs all 0 immediately; a subsequent start runs test 1 to the same result.
- start pulsed while in BCP_WAIT -> ignored: trail and assignment unchanged, and the run completes as in test 1.
